// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared types and default sizing for the reg_file_sb register file.
//   clr_state_e   : clear sequencer states (IDLE, CLEAR, DONE)
//   DEF_DATA_W    : default register width
//   DEF_NUM_REGS  : default register count
// -----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

endpackage : reg_file_pkg

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// Per-register busy vector for the pipelined register file.
// Ports:
//   clk_i, rst_n_i          : clock, synchronous active-low reset
//   clear_all_i             : drop every reservation at this edge (highest priority)
//   set_valid_i, set_idx_i  : reserve register set_idx_i
//   clr_valid_i, clr_idx_i  : release register clr_idx_i (accepted write)
//   raddr1_i, raddr2_i      : lookup indices
//   busy1_o, busy2_o        : busy bits of the current (not next) vector
// -----------------------------------------------------------------------------
module rf_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_all_i,
    input  logic              set_valid_i,
    input  logic [ADDR_W-1:0] set_idx_i,
    input  logic              clr_valid_i,
    input  logic [ADDR_W-1:0] clr_idx_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic              busy1_o,
    output logic              busy2_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Next busy vector: a new reservation beats a release of the same register.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (clear_all_i) begin
                busy_d[i] = 1'b0;
            end else if (set_valid_i && (set_idx_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if (clr_valid_i && (clr_idx_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
    end

    // Busy vector register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Lookups; indices past the last register report not-busy.
    always_comb begin
        busy1_o = 1'b0;
        busy2_o = 1'b0;
        if (32'(raddr1_i) < NUM_REGS) begin
            busy1_o = busy_q[raddr1_i];
        end else begin
            busy1_o = 1'b0;
        end
        if (32'(raddr2_i) < NUM_REGS) begin
            busy2_o = busy_q[raddr2_i];
        end else begin
            busy2_o = 1'b0;
        end
    end

endmodule : rf_scoreboard

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
// NUM_REGS x DATA_W register file with two combinational read ports, one write
// port with link-register override, a busy scoreboard and a clear sequencer
// that zeroes one register per cycle.
// Ports:
//   Clk, Reset              : clock, synchronous active-low reset
//   WE, Link, WAddr, WData  : write port (Link forces address NUM_REGS-1)
//   RAddr1/2, RData1/2      : combinational read ports
//   Issue_Valid, Issue_Dst  : scoreboard reservation
//   Busy1/2                 : busy bit of RAddr1/2
//   Clear_Req               : start the clear sequence
//   Clear_Busy, Clear_Done  : sequencer status (registered)
// Build option:
//   REG_FILE_BYPASS_EN      : when defined, an accepted write is forwarded to a
//                             read port addressing the same register in the
//                             same cycle, and that port reports not-busy.
// -----------------------------------------------------------------------------
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WE,
    input  logic              Link,
    input  logic [ADDR_W-1:0] WAddr,
    input  logic [DATA_W-1:0] WData,
    input  logic [ADDR_W-1:0] RAddr1,
    input  logic [ADDR_W-1:0] RAddr2,
    output logic [DATA_W-1:0] RData1,
    output logic [DATA_W-1:0] RData2,
    input  logic              Issue_Valid,
    input  logic [ADDR_W-1:0] Issue_Dst,
    output logic              Busy1,
    output logic              Busy2,
    input  logic              Clear_Req,
    output logic              Clear_Busy,
    output logic              Clear_Done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    clr_state_e        state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              clear_busy_q;
    logic              clear_done_q;

    logic [ADDR_W-1:0] wr_addr_s;
    logic              wr_accept_s;
    logic              issue_ok_s;
    logic              clear_start_s;
    logic              sb_busy1_s;
    logic              sb_busy2_s;
    logic              byp1_s;
    logic              byp2_s;

    assign wr_addr_s     = Link ? LAST_IDX : WAddr;
    // Writes only land while idle; DONE is not idle, so it also drops writes.
    assign wr_accept_s   = WE && (state_q == IDLE) && (32'(wr_addr_s) < NUM_REGS);
    assign issue_ok_s    = Issue_Valid && (state_q != CLEAR);
    assign clear_start_s = Clear_Req && (state_q == IDLE);

`ifdef REG_FILE_BYPASS_EN
    assign byp1_s = wr_accept_s && (wr_addr_s == RAddr1);
    assign byp2_s = wr_accept_s && (wr_addr_s == RAddr2);
`else
    assign byp1_s = 1'b0;
    assign byp2_s = 1'b0;
`endif

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk_i       (Clk),
        .rst_n_i     (Reset),
        .clear_all_i (clear_start_s),
        .set_valid_i (issue_ok_s),
        .set_idx_i   (Issue_Dst),
        .clr_valid_i (wr_accept_s),
        .clr_idx_i   (wr_addr_s),
        .raddr1_i    (RAddr1),
        .raddr2_i    (RAddr2),
        .busy1_o     (sb_busy1_s),
        .busy2_o     (sb_busy2_s)
    );

    // Storage: the sequencer owns the array while clearing.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == CLEAR) begin
            regs_q[clr_cnt_q] <= '0;
        end else if (wr_accept_s) begin
            regs_q[wr_addr_s] <= WData;
        end
    end

    // Clear sequencer with registered status outputs.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q      <= IDLE;
            clr_cnt_q    <= '0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    clear_done_q <= 1'b0;
                    if (Clear_Req) begin
                        state_q      <= CLEAR;
                        clr_cnt_q    <= '0;
                        clear_busy_q <= 1'b1;
                    end else begin
                        clear_busy_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    // Counter stops at the last register instead of wrapping.
                    if (clr_cnt_q == LAST_IDX) begin
                        state_q      <= DONE;
                        clear_busy_q <= 1'b0;
                        clear_done_q <= 1'b1;
                    end else begin
                        clr_cnt_q    <= clr_cnt_q + ADDR_W'(1);
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    clr_cnt_q    <= '0;
                    clear_busy_q <= 1'b0;
                    clear_done_q <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    clr_cnt_q    <= '0;
                    clear_busy_q <= 1'b0;
                    clear_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Read muxes; out-of-range indices read zero.
    always_comb begin
        RData1 = '0;
        RData2 = '0;
        if (byp1_s) begin
            RData1 = WData;
        end else if (32'(RAddr1) < NUM_REGS) begin
            RData1 = regs_q[RAddr1];
        end else begin
            RData1 = '0;
        end
        if (byp2_s) begin
            RData2 = WData;
        end else if (32'(RAddr2) < NUM_REGS) begin
            RData2 = regs_q[RAddr2];
        end else begin
            RData2 = '0;
        end
    end

    // A forwarded value is the completed write, so that port is not busy.
    assign Busy1      = sb_busy1_s && !byp1_s;
    assign Busy2      = sb_busy2_s && !byp2_s;
    assign Clear_Busy = clear_busy_q;
    assign Clear_Done = clear_done_q;

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int AW = 3;

    logic          Clk = 1'b0;
    logic          Reset, WE, Link, Issue_Valid, Clear_Req;
    logic [AW-1:0] WAddr, RAddr1, RAddr2, Issue_Dst;
    logic [DW-1:0] WData, RData1, RData2;
    logic          Busy1, Busy2, Clear_Busy, Clear_Done;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    // Reference model: contents, reservations, clear position
    // (-1 idle, 0..N-1 next register to zero, N = done cycle).
    logic [DW-1:0] mdl_regs [N];
    bit            mdl_busy [N];
    int            mdl_pos = -1;

    reg_file_sb dut (
        .Clk(Clk), .Reset(Reset), .WE(WE), .Link(Link), .WAddr(WAddr), .WData(WData),
        .RAddr1(RAddr1), .RAddr2(RAddr2), .RData1(RData1), .RData2(RData2),
        .Issue_Valid(Issue_Valid), .Issue_Dst(Issue_Dst), .Busy1(Busy1), .Busy2(Busy2),
        .Clear_Req(Clear_Req), .Clear_Busy(Clear_Busy), .Clear_Done(Clear_Done)
    );

    always #10 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit fwd_hit(input logic [AW-1:0] a);
        int ea;
        ea = Link ? N - 1 : int'(WAddr);
`ifdef REG_FILE_BYPASS_EN
        return (Reset === 1'b1) && WE && (mdl_pos == -1) && (ea < N) && (ea == int'(a));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (int'(a) >= N) return '0;
        if (fwd_hit(a)) return WData;
        return mdl_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (int'(a) >= N) return 1'b0;
        if (fwd_hit(a)) return 1'b0;
        return mdl_busy[a];
    endfunction

    task automatic model_update();
        int ea;
        if (!Reset) begin
            for (int i = 0; i < N; i++) begin mdl_regs[i] = '0; mdl_busy[i] = 1'b0; end
            mdl_pos = -1;
        end else if (mdl_pos == -1) begin
            ea = Link ? N - 1 : int'(WAddr);
            if (WE && ea < N) begin mdl_regs[ea] = WData; mdl_busy[ea] = 1'b0; end
            if (Issue_Valid && int'(Issue_Dst) < N) mdl_busy[Issue_Dst] = 1'b1;
            if (Clear_Req) begin
                for (int i = 0; i < N; i++) mdl_busy[i] = 1'b0;
                mdl_pos = 0;
            end
        end else if (mdl_pos < N) begin
            mdl_regs[mdl_pos] = '0;
            mdl_pos++;
        end else begin
            if (Issue_Valid && int'(Issue_Dst) < N) mdl_busy[Issue_Dst] = 1'b1;
            mdl_pos = -1;
        end
    endtask

    // Check all outputs against the model, then advance one clock.
    task automatic cycle(input string tag);
        #1;
        check_eq({tag, " rdata1"}, 32'(RData1), 32'(exp_rd(RAddr1)));
        check_eq({tag, " rdata2"}, 32'(RData2), 32'(exp_rd(RAddr2)));
        check_eq({tag, " busy1"}, 32'(Busy1), 32'(exp_busy(RAddr1)));
        check_eq({tag, " busy2"}, 32'(Busy2), 32'(exp_busy(RAddr2)));
        check_eq({tag, " clear_busy"}, 32'(Clear_Busy), 32'(mdl_pos >= 0 && mdl_pos < N));
        check_eq({tag, " clear_done"}, 32'(Clear_Done), 32'(mdl_pos == N));
        @(posedge Clk);
        model_update();
        @(negedge Clk);
    endtask

    task automatic idle();
        WE = 1'b0; Link = 1'b0; Issue_Valid = 1'b0; Clear_Req = 1'b0;
    endtask

    task automatic load_all();
        for (int a = 0; a < N; a++) begin
            idle(); WE = 1'b1; WAddr = AW'(a); WData = DW'(16'h1000 + a + 1);
            cycle("load");
        end
        idle();
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < N; a++) begin
            idle(); RAddr1 = AW'(a); RAddr2 = AW'(N - 1 - a);
            #1 check_eq(tag, 32'(RData1), 32'h0);
            cycle(tag);
        end
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        Reset = 1'b0; idle(); WAddr = '0; WData = '0; RAddr1 = '0; RAddr2 = '0; Issue_Dst = '0;
        @(posedge Clk); model_update(); @(negedge Clk);
        cycle("reset");
        Reset = 1'b1;
        check_all_zero("reset_zero");

        // Plain write, visible next cycle.
        idle(); WE = 1'b1; WAddr = 3'd3; WData = 16'hBEEF; RAddr1 = 3'd3; cycle("wr3");
        idle(); RAddr1 = 3'd3; #1 check_eq("beef_rd", 32'(RData1), 32'hBEEF); cycle("rd3");

        // Link override targets the last register.
        idle(); WE = 1'b1; Link = 1'b1; WAddr = 3'd2; WData = 16'h1234; cycle("link");
        idle(); RAddr1 = 3'd7; RAddr2 = 3'd2;
        #1 check_eq("link_r7", 32'(RData1), 32'h1234);
        check_eq("link_r2", 32'(RData2), 32'h0);
        cycle("link_rd");

        // Scoreboard set, release, set-wins.
        idle(); Issue_Valid = 1'b1; Issue_Dst = 3'd5; RAddr1 = 3'd0; cycle("iss5");
        idle(); RAddr1 = 3'd5; #1 check_eq("busy_set", 32'(Busy1), 32'h1); cycle("iss5_rd");
        idle(); WE = 1'b1; WAddr = 3'd5; WData = 16'h5555; RAddr1 = 3'd0; cycle("wr5");
        idle(); RAddr1 = 3'd5; #1 check_eq("busy_release", 32'(Busy1), 32'h0); cycle("wr5_rd");
        idle(); Issue_Valid = 1'b1; Issue_Dst = 3'd5; WE = 1'b1; WAddr = 3'd5; WData = 16'h6666;
        RAddr1 = 3'd0; cycle("iss_wr5");
        idle(); RAddr1 = 3'd5; #1 check_eq("busy_set_wins", 32'(Busy1), 32'h1); cycle("iss_wr5_rd");

        // Same-cycle read of a register being written.
        idle(); WE = 1'b1; WAddr = 3'd4; WData = 16'h00AA; RAddr2 = 3'd4;
`ifdef REG_FILE_BYPASS_EN
        #1 check_eq("byp_same", 32'(RData2), 32'h00AA);
`else
        #1 check_eq("byp_same", 32'(RData2), 32'h0);
`endif
        cycle("byp");
        idle(); RAddr2 = 3'd4; #1 check_eq("byp_next", 32'(RData2), 32'h00AA); cycle("byp_next");

        // Randomised traffic against the model.
        for (int k = 0; k < 300; k++) begin
            WE = 1'($urandom_range(0, 1)); Link = ($urandom_range(0, 5) == 0);
            WAddr = AW'($urandom); WData = DW'($urandom);
            RAddr1 = AW'($urandom); RAddr2 = AW'($urandom);
            Issue_Valid = 1'($urandom_range(0, 1)); Issue_Dst = AW'($urandom);
            Clear_Req = ($urandom_range(0, 39) == 0);
            cycle("rand");
        end
        idle();
        for (int k = 0; k < 20 && mdl_pos != -1; k++) cycle("drain");
        #1 check_eq("drain_idle", 32'(Clear_Busy), 32'h0);

        // Full clear with a write attempted mid-sequence.
        load_all();
        Clear_Req = 1'b1; cycle("clr_start"); idle();
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 3) begin WE = 1'b1; WAddr = 3'd1; WData = 16'hFFFF; end
            else WE = 1'b0;
            RAddr1 = AW'(k % N);
            #1;
            if (Clear_Busy === 1'b1) busy_cnt++;
            if (Clear_Done === 1'b1) done_cnt++;
            cycle("clr_run");
        end
        check_eq("clr_busy_cycles", 32'(busy_cnt), 32'd8);
        check_eq("clr_done_pulses", 32'(done_cnt), 32'd1);
        check_all_zero("clr_zero");

        // Reset during the third clear cycle.
        load_all();
        Clear_Req = 1'b1; cycle("rclr_start"); idle();
        cycle("rclr_c1"); cycle("rclr_c2");
        Reset = 1'b0; cycle("rclr_rst");
        Reset = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (Clear_Done === 1'b1) done_cnt++;
            cycle("rclr_after");
        end
        check_eq("rclr_no_done", 32'(done_cnt), 32'd0);
        check_eq("rclr_idle", 32'(Clear_Busy), 32'h0);
        check_all_zero("rclr_zero");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_reg_file_sb

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the LC-3 8x16 register file: NUM_REGS x DATA_W storage, two combinational read ports, one write port, link-register destination override.
- Adds a per-register busy scoreboard for pipelined datapaths and a multi-cycle clear sequencer that zeroes the file one register per cycle.
- Sits between decode (read/issue side) and writeback (write side) of the pipelined core.

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 8, register count; any value >= 2, need not be a power of 2.
- ADDR_W, $clog2(NUM_REGS), derived address width; not overridden.

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset.
- WE  in  1  write enable.
- Link  in  1  1: write address forced to NUM_REGS-1; 0: use WAddr.
- WAddr  in  ADDR_W  write register index.
- WData  in  DATA_W  write data.
- RAddr1  in  ADDR_W  read port 1 index.
- RAddr2  in  ADDR_W  read port 2 index.
- RData1  out  DATA_W  read port 1 data.
- RData2  out  DATA_W  read port 2 data.
- Issue_Valid  in  1  reserve a destination in the scoreboard.
- Issue_Dst  in  ADDR_W  register to reserve.
- Busy1  out  1  busy bit of RAddr1.
- Busy2  out  1  busy bit of RAddr2.
- Clear_Req  in  1  start clear sequence.
- Clear_Busy  out  1  high while clear sequence runs.
- Clear_Done  out  1  one-cycle pulse after the last register is zeroed.

Behaviour:
- Reset low at a rising edge: all registers 0, busy bits 0, FSM IDLE, counter 0, Clear_Busy 0, Clear_Done 0. Reset overrides everything, including a clear in progress.
- Effective write address: EA = Link ? NUM_REGS-1 : WAddr.
- Write: when WE=1 and FSM=IDLE, regs[EA] <= WData at the edge. If EA >= NUM_REGS, no write.
- Read: RDataN = regs[RAddrN], combinational, zero latency. RAddrN >= NUM_REGS returns 0 and BusyN=0.
- Scoreboard, per bit i each edge:
  - Set if Issue_Valid and Issue_Dst==i.
  - Otherwise cleared if a write to EA==i is accepted.
  - Set and clear on the same register in the same cycle: set wins (new reservation).
  - Issue_Valid ignored during CLEAR.
  - BusyN is combinational from the current bits, not the next-state bits.
- Clear FSM:
  - IDLE -> CLEAR on Clear_Req=1; counter <= 0, all busy bits cleared at the same edge.
  - CLEAR: regs[counter] <= 0 and counter++ each cycle; Clear_Busy=1; WE ignored; Clear_Req ignored.
  - After writing NUM_REGS-1: -> DONE.
  - DONE: Clear_Done=1 for one cycle, then -> IDLE.
  - Clear length: NUM_REGS cycles in CLEAR plus 1 in DONE.
  - Reads during CLEAR return current contents (partially cleared).
- Counter is ADDR_W bits and never wraps past NUM_REGS-1.

Optional Feature:
- Macro REG_FILE_BYPASS_EN.
- Defined: if WE=1, FSM=IDLE, EA valid and EA==RAddrN, then RDataN=WData in the same cycle (write-through forwarding), and BusyN=0 for that port.
- Undefined: reads return stored contents only; the written value is visible the cycle after the edge.

Decomposition:
- Package reg_file_pkg: clear FSM state enum (IDLE, CLEAR, DONE) and default DATA_W/NUM_REGS constants.
- One sub-module, rf_scoreboard: busy vector, set/clear priority, and the two busy lookups.
- Storage array, read muxing and clear FSM stay in reg_file_sb.

Test Plan:
- Reset, then WE=1, WAddr=3, WData=16'hBEEF -> next cycle RAddr1=3 gives RData1=16'hBEEF; all other registers read 0.
- Link=1, WAddr=2, WData=16'h1234 -> regs[7]=16'h1234, regs[2] unchanged at 0.
- Issue_Valid, Issue_Dst=5 -> Busy1=1 with RAddr1=5 next cycle. Write to 5 -> Busy1=0. Issue and write to 5 in the same cycle -> stays 1.
- Load all 8 registers with nonzero values, pulse Clear_Req:
  - Clear_Busy high 8 cycles, then Clear_Done pulses 1 cycle.
  - All registers read 0 afterwards.
  - A WE=1 write issued mid-clear is dropped.
- Reset low at cycle 3 of a clear -> all registers 0, FSM IDLE, no Clear_Done pulse.
- With REG_FILE_BYPASS_EN: WE=1, WAddr=4, WData=16'h00AA, RAddr2=4 -> RData2=16'h00AA in the same cycle. Without the macro: old value in that cycle, 16'h00AA the next cycle.
